// File: rtl/md_div_unit.sv
// RV32M divide unit: DIV/DIVU/REM/REMU via 32-step restoring division.
// Divide-by-zero and signed overflow finish early; flush aborts, rst clears all.
module md_div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic            op_rem;
    logic            neg_q;
    logic            neg_r;

    logic            accept;
    logic            is_signed;
    logic            s1_neg;
    logic            s2_neg;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] fix_res;

    // Request decode at the accept point
    assign accept    = valid_i && (state == IDLE) && !flush_i && funct3_i[2];
    assign is_signed = !funct3_i[0];
    assign s1_neg    = is_signed && src1_i[XLEN-1];
    assign s2_neg    = is_signed && src2_i[XLEN-1];
    assign div_zero  = (src2_i == '0);
    assign overflow  = is_signed && (src1_i == MIN_NEG) && (src2_i == '1);
    assign special   = div_zero || overflow;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = funct3_i[1] ? src1_i : '1;
        end else begin
            special_res = funct3_i[1] ? '0 : MIN_NEG;
        end
    end

    // One restoring step: shift {acc,quo}, trial-subtract the divisor
    assign shifted = {acc, quo[XLEN-1]};
    assign trial   = shifted - {1'b0, dvs};

    assign fix_res = op_rem ? (neg_r ? (XLEN'(0) - acc) : acc)
                            : (neg_q ? (XLEN'(0) - quo) : quo);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = special ? DONE : CALC;
            CALC:    if (cnt == LAST_STEP) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush_i) begin
            next_state = IDLE;
        end
    end

    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        valid_o = 1'b0;
        case (state)
            IDLE:    ready_o = 1'b1;
            CALC:    busy_o  = 1'b1;
            FIX:     busy_o  = 1'b1;
            DONE: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
            end
            default: ready_o = 1'b0;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            quo      <= '0;
            dvs      <= '0;
            op_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
        end else if (accept) begin
            cnt    <= '0;
            acc    <= '0;
            quo    <= s1_neg ? (XLEN'(0) - src1_i) : src1_i;
            dvs    <= s2_neg ? (XLEN'(0) - src2_i) : src2_i;
            op_rem <= funct3_i[1];
            neg_q  <= s1_neg ^ s2_neg;
            neg_r  <= s1_neg;
            if (special) begin
                result_o <= special_res;
            end
        end else if (state == CALC && !flush_i) begin
            cnt <= cnt + CW'(1);
            if (!trial[XLEN]) begin
                acc <= trial[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
                acc <= shifted[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b0};
            end
        end else if (state == FIX && !flush_i) begin
            result_o <= fix_res;
        end
    end

endmodule

// File: doc/md_div_unit.md
MD_DIV_UNIT -- requirements
Module: md_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 supported.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  operation request from ID/EX.
REQ-005 SHALL have port funct3_i  input  3  RV32M funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port src1_i  input  32  dividend (rs1).
REQ-007 SHALL have port src2_i  input  32  divisor (rs2).
REQ-008 SHALL have port flush_i  input  1  pipeline kill; abort current operation.
REQ-009 SHALL have port ready_o  output  1  high only in IDLE; request accepted when valid_i && ready_o && !flush_i && funct3_i[2].
REQ-010 SHALL have port busy_o  output  1  high in CALC, FIX and DONE; drives pipeline stall.
REQ-011 SHALL have port valid_o  output  1  one-cycle result pulse toward MEM/WB.
REQ-012 SHALL have port result_o  output  32  quotient (DIV/DIVU) or remainder (REM/REMU); held until next accept.

Function
REQ-013 SHALL use FSM states IDLE, CALC, FIX, DONE; all outputs derive from registers.
REQ-014 SHALL, on accept, latch op, operand signs and unsigned magnitudes (negated only for DIV/REM with negative operand), and clear a 6-bit iteration counter.
REQ-015 SHALL go IDLE->DONE directly on accept when divisor is zero or signed overflow (DIV/REM, src1=0x80000000, src2=0xFFFFFFFF); otherwise IDLE->CALC.
REQ-016 SHALL, in CALC, perform one restoring-division step per cycle: shift {acc,q} left 1, trial-subtract {1'b0,divisor} from 33-bit acc, keep and set q[0]=1 if non-negative, else restore and set q[0]=0.
REQ-017 SHALL stay in CALC exactly 32 cycles (counter 0..31), then go to FIX.
REQ-018 SHALL, in FIX, negate quotient if signs of operands differ (signed ops only), negate remainder if dividend negative (signed ops only), and load result register; then go to DONE.
REQ-019 SHALL assert valid_o for exactly the one DONE cycle, then return to IDLE.
REQ-020 SHALL give latency from accept edge: special case valid_o at cycle +1; normal case valid_o at cycle +34.
REQ-021 SHALL return, for divide-by-zero: DIV/DIVU 0xFFFFFFFF, REM/REMU src1 unchanged.
REQ-022 SHALL return, for signed overflow: DIV 0x80000000, REM 0x00000000.
REQ-023 SHALL ignore valid_i while not in IDLE and ignore valid_i when funct3_i[2]=0.
REQ-024 SHALL, on flush_i in any state, go to IDLE next cycle with no valid_o; flush_i with valid_i in IDLE is not accepted (flush wins).
REQ-025 SHALL keep result_o unchanged on flush.
REQ-026 SHALL accept a new request in the cycle after DONE (back-to-back issue).

Reset
REQ-027 SHALL, on rst high at a rising edge, force state IDLE, counter 0, acc/q 0, result_o 0x00000000, valid_o 0, busy_o 0, ready_o 1 the next cycle.
REQ-028 SHALL give rst priority over flush_i and valid_i, including mid-CALC.

Verification
REQ-029 SHALL cover DIV 0xFFFFFFF9/0x00000002 -> result 0xFFFFFFFD at +34; REM same operands -> 0xFFFFFFFF.
REQ-030 SHALL cover DIVU 0xFFFFFFFF/0x00000010 -> 0x0FFFFFFF; REMU -> 0x0000000F; busy_o high cycles +1..+34.
REQ-031 SHALL cover DIV 0x00000064/0 -> 0xFFFFFFFF at +1; REM 0x00000064/0 -> 0x00000064 at +1.
REQ-032 SHALL cover DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at +1; REM -> 0x00000000.
REQ-033 SHALL cover flush_i at cycle +10 of DIVU -> no valid_o, ready_o 1 at +11, following DIVU 100/7 -> 0x0000000E.
REQ-034 SHALL cover rst at cycle +20 of DIV -> next cycle result_o 0, valid_o 0, ready_o 1; no stale valid_o afterwards.
